// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    LOCKED  = 2'd2
  } arb_state_e;

  // Port identifiers; also the bit positions in the 2-bit req/gnt vectors.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // DMA starvation counter width and the count that forces a DMA grant.
  localparam int                  STARVE_W     = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = 4'd15;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-input round-robin picker. Bit 0 is the CPU, bit 1 the DMA port.
// A set mask bit removes that requester from consideration this cycle.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic [1:0] elig;

  // One-hot grant: on contention the port not granted last wins.
  always_comb begin
    elig  = req_i & ~mask_i;
    gnt_o = elig;
    if (elig == 2'b11) begin
      gnt_o = (last_i == PORT_CPU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) single-memory arbiter with round-robin fairness,
// a CPU bus lock for atomic sequences and a DMA starvation escape.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // CPU port
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic          cpu_lock_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  // DMA port
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_rdata_o,
  // Memory side
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wen_o,
  input  logic [DW-1:0] mem_rdata_i
);

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic [STARVE_W-1:0] starv_q, starv_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_port_q, rd_port_d;
  logic [DW-1:0]       cpu_rdata_q, dma_rdata_q;

  logic [1:0] req, mask, gnt;
  logic       locked, force_dma, gnt_we;

  // Requests are suppressed while reset is held so no grant escapes.
  assign req = rst ? 2'b00 : {dma_req_i, cpu_req_i};

  // LOCKED shuts out DMA; a starved DMA that is still asking shuts out the CPU.
  assign locked    = (state_q == LOCKED);
  assign force_dma = (starv_q == STARVE_LIMIT) && dma_req_i;
  assign mask      = {locked, force_dma};

  rr_pick u_pick (
    .req_i  (req),
    .last_i (last_q),
    .mask_i (mask),
    .gnt_o  (gnt)
  );

  assign cpu_gnt_o = gnt[PORT_CPU];
  assign dma_gnt_o = gnt[PORT_DMA];

  // Memory command mux; address and data hold their last value when idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_we  = 1'b0;
    if (gnt[PORT_DMA]) begin
      addr_d  = dma_addr_i;
      wdata_d = dma_wdata_i;
      gnt_we  = dma_we_i;
    end else if (gnt[PORT_CPU]) begin
      addr_d  = cpu_addr_i;
      wdata_d = cpu_wdata_i;
      gnt_we  = cpu_we_i;
    end
  end

  assign mem_addr_o  = addr_d;
  assign mem_wdata_o = wdata_d;
  assign mem_wen_o   = gnt_we;

  // A read grant leaves a tagged response pending for exactly one cycle.
  always_comb begin
    rd_pend_d = (|gnt) && !gnt_we;
    rd_port_d = gnt[PORT_DMA];
  end

  // Memory data arrives one cycle after the address; steer it to the
  // tagged port and let the other port keep its last returned word.
  assign cpu_rvalid_o = rd_pend_q && (rd_port_q == PORT_CPU);
  assign dma_rvalid_o = rd_pend_q && (rd_port_q == PORT_DMA);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
  assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : dma_rdata_q;

  // Next-state: round-robin history, starvation counter and ownership FSM.
  // OWN_CPU marks a cycle following an unlocked CPU grant; a CPU grant taken
  // with cpu_lock high moves straight to LOCKED so DMA is shut out from the
  // very next cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    starv_d = starv_q;

    if (gnt[PORT_CPU])      last_d = PORT_CPU;
    else if (gnt[PORT_DMA]) last_d = PORT_DMA;

    if (gnt[PORT_DMA])                                starv_d = '0;
    else if (locked)                                  starv_d = dma_req_i ? starv_q + 1'b1 : '0;
    else if (starv_q == STARVE_LIMIT && !dma_req_i)   starv_d = '0;

    unique case (state_q)
      IDLE, OWN_CPU: begin
        if (gnt[PORT_CPU]) state_d = cpu_lock_i ? LOCKED : OWN_CPU;
        else               state_d = IDLE;
      end
      LOCKED: begin
        if (!cpu_lock_i || starv_d == STARVE_LIMIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_DMA;
      starv_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= PORT_CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      starv_q     <= starv_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_pend_q   <= rd_pend_d;
      rd_port_q   <= rd_port_d;
      cpu_rdata_q <= cpu_rdata_o;
      dma_rdata_q <= dma_rdata_o;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt_o, cpu_rvalid_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt_o, dma_rvalid_o;
  logic [DW-1:0] dma_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_wen_o;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_lock_i   (cpu_lock),
    .cpu_gnt_o    (cpu_gnt_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .dma_req_i    (dma_req),
    .dma_we_i     (dma_we),
    .dma_addr_i   (dma_addr),
    .dma_wdata_i  (dma_wdata),
    .dma_gnt_o    (dma_gnt_o),
    .dma_rvalid_o (dma_rvalid_o),
    .dma_rdata_o  (dma_rdata_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wen_o    (mem_wen_o),
    .mem_rdata_i  (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // Synchronous memory driven only by the DUT's memory port.
  logic [DW-1:0] env_mem [256];
  bit            env_wr  [256];
  always @(posedge clk) begin
    if (mem_wen_o) begin
      env_mem[mem_addr_o[7:0]] <= mem_wdata_o;
      env_wr[mem_addr_o[7:0]]  <= 1'b1;
    end
    mem_rdata <= env_wr[mem_addr_o[7:0]] ? env_mem[mem_addr_o[7:0]] : init_val(mem_addr_o[7:0]);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, who owns the bus, fairness history,
  // consecutive-starved count, and the one outstanding read response.
  logic [DW-1:0] ref_mem [256];
  bit            m_locked, m_last, m_pv, m_pport;
  int            m_starve;
  logic [DW-1:0] m_pdata, m_crd, m_drd, m_wdata;
  logic [AW-1:0] m_addr;
  bit [1:0]      m_win;
  bit [1:0]      obs_gnt, obs_rv;
  bit            obs_wen;

  task automatic model_reset();
    m_locked = 0; m_last = 1; m_starve = 0; m_pv = 0; m_pport = 0;
    m_pdata = '0; m_crd = '0; m_drd = '0; m_addr = '0; m_wdata = '0; m_win = 2'b00;
  endtask

  task automatic model_step();
    bit c_ok, d_ok, we, crv, drv, nl;
    bit [1:0] win;
    int ns;
    c_ok = cpu_req && !(m_starve == 15 && dma_req);
    d_ok = dma_req && !m_locked;
    if (c_ok && d_ok) win = m_last ? 2'b01 : 2'b10;
    else              win = {d_ok, c_ok};
    crv = m_pv && !m_pport;
    drv = m_pv && m_pport;
    if (crv) m_crd = m_pdata;
    if (drv) m_drd = m_pdata;
    we = 0;
    if (win[0]) begin m_addr = cpu_addr; m_wdata = cpu_wdata; we = cpu_we; end
    if (win[1]) begin m_addr = dma_addr; m_wdata = dma_wdata; we = dma_we; end
    chk("gnt", {dma_gnt_o, cpu_gnt_o}, win);
    chk("mem_wen", mem_wen_o, we);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("rvalid", {dma_rvalid_o, cpu_rvalid_o}, {drv, crv});
    chk("cpu_rdata", cpu_rdata_o, m_crd);
    chk("dma_rdata", dma_rdata_o, m_drd);
    if (we) ref_mem[m_addr[7:0]] = m_wdata;
    m_pv    = (win != 2'b00) && !we;
    m_pport = win[1];
    m_pdata = ref_mem[m_addr[7:0]];
    if (win[1])                            ns = 0;
    else if (m_locked)                     ns = dma_req ? m_starve + 1 : 0;
    else if (m_starve == 15 && !dma_req)   ns = 0;
    else                                   ns = m_starve;
    if (m_locked) nl = cpu_lock && (ns != 15);
    else          nl = win[0] && cpu_lock;
    if (win[0]) m_last = 0;
    if (win[1]) m_last = 1;
    m_locked = nl;
    m_starve = ns;
    m_win    = win;
  endtask

  task automatic tick();
    @(negedge clk);
    obs_gnt = {dma_gnt_o, cpu_gnt_o};
    obs_rv  = {dma_rvalid_o, cpu_rvalid_o};
    obs_wen = mem_wen_o;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " gnt"}, {dma_gnt_o, cpu_gnt_o}, 2'b00);
    chk({tag, " rvalid"}, {dma_rvalid_o, cpu_rvalid_o}, 2'b00);
    chk({tag, " rdata"}, {dma_rdata_o, cpu_rdata_o}, 64'h0);
    chk({tag, " mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, " mem_wen"}, mem_wen_o, 1'b0);
  endtask

  initial begin
    int first, second, n_c, n_d, n_idle, n_rep, n_wen;
    bit [1:0] prev;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Both read at once: CPU first, DMA next with CPU data, then DMA data.
    cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h20;
    tick(); chk("032 c0 gnt", obs_gnt, 2'b01);
    cpu_req = 0;
    tick(); chk("032 c1 gnt", obs_gnt, 2'b10); chk("032 c1 rv", obs_rv, 2'b01);
    chk("032 c1 cpu_rdata", cpu_rdata_o, init_val(8'h10));
    dma_req = 0;
    tick(); chk("032 c2 rv", obs_rv, 2'b10);
    chk("032 c2 dma_rdata", dma_rdata_o, init_val(8'h20));

    // CPU write then DMA readback of the same word.
    n_wen = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
    tick(); n_wen += obs_wen;
    cpu_req = 0; cpu_we = 0; dma_req = 1; dma_addr = 32'h40;
    tick(); n_wen += obs_wen;
    dma_req = 0;
    tick(); n_wen += obs_wen;
    chk("033 wen cycles", n_wen, 1);
    chk("033 dma_rdata", dma_rdata_o, 32'hDEAD_BEEF);
    chk("033 dma_rvalid", obs_rv, 2'b10);

    // Locked CPU stream vs. waiting DMA: forced DMA grant every 17 cycles.
    first = -1; second = -1;
    cpu_lock = 1; cpu_req = 1; cpu_addr = 32'h80; dma_req = 1; dma_addr = 32'h44;
    for (int c = 0; c < 60 && second < 0; c++) begin
      tick();
      if (obs_gnt[1]) begin
        if (first < 0) first = c;
        else           second = c;
      end
      if (obs_gnt[0]) cpu_addr = (cpu_addr + 4) & 32'hFC;
    end
    chk("034 first dma_gnt cycle", first, 16);
    chk("034 second dma_gnt cycle", second, 33);
    cpu_lock = 0; cpu_req = 0; dma_req = 0;
    tick(); tick();

    // Lock raised together with a DMA request while CPU was granted last.
    cpu_req = 1; cpu_addr = 32'h30;
    tick();
    dma_req = 1; dma_addr = 32'h34; cpu_lock = 1;
    tick(); chk("026 dma wins", obs_gnt, 2'b10);
    dma_req = 0;
    tick(); chk("026 cpu next", obs_gnt, 2'b01);
    cpu_req = 0; cpu_lock = 0;
    tick(); tick();

    // Continuous requests from both: strict alternation, no idle cycles.
    n_c = 0; n_d = 0; n_idle = 0; n_rep = 0; prev = 2'b00;
    cpu_req = 1; dma_req = 1; cpu_addr = 32'h08; dma_addr = 32'h0C;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (obs_gnt == 2'b01) n_c++;
      else if (obs_gnt == 2'b10) n_d++;
      else n_idle++;
      if (obs_gnt == prev) n_rep++;
      prev = obs_gnt;
    end
    chk("035 cpu grants", n_c, 10);
    chk("035 dma grants", n_d, 10);
    chk("035 idle cycles", n_idle, 0);
    chk("035 repeats", n_rep, 0);
    cpu_req = 0; dma_req = 0;
    tick();

    // Reset the cycle after a CPU read grant.
    cpu_req = 1; cpu_addr = 32'h18;
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("036");
    cpu_req = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(); chk("036 no rvalid", obs_rv, 2'b00);
    tick();

    // Random traffic; each request is held until its grant.
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || m_win[0]) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        cpu_wdata = $urandom;
      end
      if (!dma_req || m_win[1]) begin
        dma_req   = ($urandom_range(0, 3) != 0);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        dma_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) cpu_lock = ~cpu_lock;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, 32, address width.
REQ-002 SHALL have parameter DW, 32, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU access request; held until cpu_gnt.
REQ-006 cpu_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-007 cpu_addr  input  AW  CPU byte address.
REQ-008 cpu_wdata  input  DW  CPU write data.
REQ-009 cpu_lock  input  1  CPU holds the bus for an atomic sequence.
REQ-010 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-011 cpu_rvalid  output  1  CPU read data valid.
REQ-012 cpu_rdata  output  DW  CPU read data.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same directions, widths and meanings as REQ-005..REQ-012, for the DMA/peripheral requester.
REQ-014 mem_addr  output  AW  address to the memory unit.
REQ-015 mem_wdata  output  DW  write data to the memory unit.
REQ-016 mem_wen  output  1  memory write enable.
REQ-017 mem_rdata  input  DW  memory read data, valid one cycle after the address is presented.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt is combinational from req and internal state, one-cycle pulse per accepted access.
REQ-019 SHALL drive mem_addr/mem_wdata/mem_wen from the granted port in the grant cycle; with no grant, mem_wen = 0 and mem_addr/mem_wdata hold their last values.
REQ-020 Arbitration SHALL be round-robin using a last_grant register: when both request, the port not granted last wins; a single requester always wins, except per REQ-023.
REQ-021 Read grant (we = 0) SHALL raise that port's rvalid exactly one cycle later with rdata = mem_rdata; the other port's rvalid stays 0.
REQ-022 Write grant SHALL complete in the grant cycle; no rvalid.
REQ-023 FSM states IDLE, OWN_CPU, LOCKED: IDLE->OWN_CPU on CPU grant; OWN_CPU->LOCKED if cpu_lock = 1 at that grant; LOCKED->IDLE when cpu_lock falls; in LOCKED, dma_gnt SHALL be 0 and CPU wins regardless of last_grant; OWN_CPU->IDLE next cycle otherwise.
REQ-024 Back-to-back accesses SHALL be supported: a new grant may occur in the same cycle as the previous read's rvalid (throughput 1 access/cycle).
REQ-025 rdata SHALL be registered with the port tag; rdata of a non-targeted port keeps its previous value.
REQ-026 Simultaneous lock assert and DMA request with last_grant = CPU: DMA SHALL win (lock applies only after a CPU grant).
REQ-027 A DMA starvation counter (4 bits) SHALL count consecutive LOCKED cycles with dma_req = 1; at 15 the FSM SHALL force LOCKED->IDLE and grant DMA next, ignoring cpu_lock for that one access; counter clears on dma_gnt.

Reset
REQ-028 On rst: FSM = IDLE, last_grant = DMA (CPU favoured first), starvation counter = 0, all gnt/rvalid = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, mem_wen = 0.
REQ-029 Reset mid-access SHALL discard any pending rvalid; no rvalid after rst deasserts without a new grant.

Structure
REQ-030 Shared package SHALL hold the FSM state enum (IDLE, OWN_CPU, LOCKED), port-ID constants (PORT_CPU = 0, PORT_DMA = 1) and starvation limit constant (15).
REQ-031 One sub-module rr_pick (2-input round-robin picker: req[1:0], last, mask -> gnt[1:0]) is natural; the rest is flat.

Verification
REQ-032 After reset, cpu_req and dma_req both 1 with reads at 0x10/0x20 -> cycle 0 cpu_gnt, cycle 1 dma_gnt plus cpu_rvalid with mem[0x10], cycle 2 dma_rvalid with mem[0x20].
REQ-033 CPU write 0xDEADBEEF to 0x40, then DMA read 0x40 -> mem_wen = 1 for exactly one cycle; dma_rdata = 0xDEADBEEF.
REQ-034 cpu_lock = 1 and continuous CPU reads with dma_req = 1 -> no dma_gnt for 15 cycles, forced dma_gnt on cycle 16, counter back to 0.
REQ-035 Continuous requests from both ports for 20 cycles -> grants alternate strictly, 10 each, no idle cycle.
REQ-036 rst asserted the cycle after a CPU read grant -> cpu_rvalid stays 0, all outputs at reset values asynchronously.
